icache_ctrl: RTL and testbench

// Miss/hit control FSM for the direct-mapped I-cache; sits between the IFU and the tag array/data array/AXI read port.

---
 rtl/icache_if.sv | 45 ++++
 rtl/icache_ctrl.sv | 134 +++++++++++++
 tb/tb_icache_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// IFU / tag-array / data-array / AXI-read bundle for the I-cache controller.
// The slave modport is the controller's view; master is the surrounding environment.
interface icache_if #(
  parameter int TAG_LEN = 23,
  parameter int IDX_LEN = 5
);
  logic               ifu_req_valid_i;
  logic               ifu_req_ready_o;
  logic [31:0]        ifu_addr_i;
  logic               ifu_rsp_valid_o;
  logic [31:0]        ifu_rdata_o;
  logic               fence_i_i;
  logic [TAG_LEN-1:0] tag_o;
  logic [IDX_LEN-1:0] index_o;
  logic               tag_write_o;
  logic               tag_hit_i;
  logic [127:0]       data_line_i;
  logic               data_we_o;
  logic [1:0]         data_beat_o;
  logic [31:0]        data_wdata_o;
  logic               mem_arvalid_o;
  logic               mem_arready_i;
  logic [31:0]        mem_araddr_o;
  logic [7:0]         mem_arlen_o;
  logic               mem_rvalid_i;
  logic               mem_rready_o;
  logic [31:0]        mem_rdata_i;
  logic               mem_rlast_i;

  modport slave (
    input  ifu_req_valid_i, ifu_addr_i, fence_i_i, tag_hit_i, data_line_i,
           mem_arready_i, mem_rvalid_i, mem_rdata_i, mem_rlast_i,
    output ifu_req_ready_o, ifu_rsp_valid_o, ifu_rdata_o, tag_o, index_o,
           tag_write_o, data_we_o, data_beat_o, data_wdata_o,
           mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_rready_o
  );

  modport master (
    output ifu_req_valid_i, ifu_addr_i, fence_i_i, tag_hit_i, data_line_i,
           mem_arready_i, mem_rvalid_i, mem_rdata_i, mem_rlast_i,
    input  ifu_req_ready_o, ifu_rsp_valid_o, ifu_rdata_o, tag_o, index_o,
           tag_write_o, data_we_o, data_beat_o, data_wdata_o,
           mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_rready_o
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped I-cache miss/hit controller: owns the per-line valid bits,
// looks up the tag array, answers hits from the data array and refills a
// 16-byte line with a 4-beat AXI INCR burst on a miss. fence.i clears all lines.
module icache_ctrl #(
  parameter int TAG_LEN = 23,
  parameter int IDX_LEN = 5,
  parameter int OFF_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  icache_if.slave bus
);
  localparam int LINES = 1 << IDX_LEN;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS_AR, MISS_R} state_t;

  state_t             state_q, state_d;
  logic [31:2]        addr_q, addr_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               fence_pend_q, fence_pend_d;

  logic [IDX_LEN-1:0] idx;
  logic [OFF_LEN-3:0] off;
  logic               hit;
  logic               ready, rsp_valid, data_we, tag_write, arvalid, rready;
  logic [31:0]        rdata, wdata;
  logic               unused_addr_bits;

  // Fetches are word aligned, so the byte-select bits are dropped on latch.
  assign unused_addr_bits = ^bus.ifu_addr_i[1:0];

  assign idx = addr_q[OFF_LEN +: IDX_LEN];
  assign off = addr_q[OFF_LEN-1:2];
  // The tag array carries no valid bit; a stale tag match must not count as a hit.
  assign hit = bus.tag_hit_i & valid_q[idx];

  assign bus.tag_o           = addr_q[31 -: TAG_LEN];
  assign bus.index_o         = idx;
  assign bus.mem_araddr_o    = {addr_q[31:OFF_LEN], {OFF_LEN{1'b0}}};
  assign bus.mem_arlen_o     = 8'd3;
  assign bus.data_beat_o     = cnt_q;
  assign bus.ifu_req_ready_o = ready;
  assign bus.ifu_rsp_valid_o = rsp_valid;
  assign bus.ifu_rdata_o     = rdata;
  assign bus.data_we_o       = data_we;
  assign bus.data_wdata_o    = wdata;
  assign bus.tag_write_o     = tag_write;
  assign bus.mem_arvalid_o   = arvalid;
  assign bus.mem_rready_o    = rready;

  // Next-state and output decode for the lookup / refill sequence.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    fence_pend_d = fence_pend_q;
    ready        = 1'b0;
    rsp_valid    = 1'b0;
    rdata        = '0;
    data_we      = 1'b0;
    wdata        = '0;
    tag_write    = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;

    // A fence seen mid-request is deferred so the in-flight fetch completes.
    if (state_q != IDLE && bus.fence_i_i) fence_pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.fence_i_i || fence_pend_q) begin
          valid_d      = '0;
          fence_pend_d = 1'b0;
        end else begin
          ready = 1'b1;
          if (bus.ifu_req_valid_i) begin
            addr_d  = bus.ifu_addr_i[31:2];
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (hit) begin
          rsp_valid = 1'b1;
          rdata     = bus.data_line_i[{off, 5'd0} +: 32];
          state_d   = IDLE;
        end else begin
          state_d = MISS_AR;
        end
      end
      MISS_AR: begin
        arvalid = 1'b1;
        if (bus.mem_arready_i) begin
          cnt_d   = 2'd0;
          state_d = MISS_R;
        end
      end
      MISS_R: begin
        rready = 1'b1;
        if (bus.mem_rvalid_i) begin
          data_we = 1'b1;
          wdata   = bus.mem_rdata_i;
          cnt_d   = cnt_q + 2'd1;
          // rlast closes the line even if fewer beats arrived than expected.
          if (bus.mem_rlast_i) begin
            tag_write    = 1'b1;
            valid_d[idx] = 1'b1;
            state_d      = LOOKUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bookkeeping registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      valid_q      <= '0;
      cnt_q        <= '0;
      fence_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      fence_pend_q <= fence_pend_d;
    end
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: behavioural tag/data arrays, a sequential AXI read
// slave, directed scenarios and a randomized run against a line-level cache model.
module tb_icache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  icache_if #(.TAG_LEN(23), .IDX_LEN(5)) bus ();

  icache_ctrl #(.TAG_LEN(23), .IDX_LEN(5), .OFF_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Environment: tag and data arrays with combinational read, write on clock.
  bit   [22:0]  tag_arr  [32];
  bit   [127:0] data_arr [32];
  int           we_cnt = 0;
  int           tw_cnt = 0;
  logic [7:0]   beat_hist = '0;
  logic [4:0]   tw_idx = '0;
  logic [22:0]  tw_tag = '0;

  assign bus.tag_hit_i   = (tag_arr[bus.index_o] == bus.tag_o);
  assign bus.data_line_i = data_arr[bus.index_o];

  always @(posedge clk) begin
    if (bus.data_we_o) begin
      data_arr[bus.index_o][{bus.data_beat_o, 5'd0} +: 32] <= bus.data_wdata_o;
      we_cnt    <= we_cnt + 1;
      beat_hist <= {beat_hist[5:0], bus.data_beat_o};
    end
    if (bus.tag_write_o) begin
      tag_arr[bus.index_o] <= bus.tag_o;
      tw_cnt <= tw_cnt + 1;
      tw_idx <= bus.index_o;
      tw_tag <= bus.tag_o;
    end
  end

  // Reference model: which line (tag) each index currently holds.
  bit         ref_valid [32];
  logic [22:0] ref_tag  [32];
  bit          fixed_mode = 1'b0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] slave_word(input logic [31:0] base, input int beat);
    if (fixed_mode) return 32'(32'h11 * (beat + 1));
    return memfn(base + 32'(4 * beat));
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ifu_req_valid_i = 1'b0;
    bus.fence_i_i       = 1'b0;
    bus.mem_arready_i   = 1'b0;
    bus.mem_rvalid_i    = 1'b0;
    bus.mem_rlast_i     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  // One IFU fetch with the AXI slave played inline; returns what was observed.
  task automatic fetch(input logic [31:0] a, input int ar_wait, input bit gaps_en,
                       input int fence_beat, output logic [31:0] rd, output int lat,
                       output bit saw_ar, output bit ar_bad, output int gaps, output bit ok);
    int n, w, beat;
    logic [31:0] base;
    rd = '0; lat = 0; saw_ar = 0; ar_bad = 0; gaps = 0; ok = 0;
    w = 0; beat = 0; base = {a[31:4], 4'h0};
    n = 0;
    while (!bus.ifu_req_ready_o && n < 50) begin @(negedge clk); n++; end
    bus.ifu_req_valid_i = 1'b1;
    bus.ifu_addr_i      = a;
    @(negedge clk);
    bus.ifu_req_valid_i = 1'b0;
    for (int c = 1; c < 200 && !ok; c++) begin
      if (bus.ifu_rsp_valid_o) begin
        ok = 1; lat = c; rd = bus.ifu_rdata_o;
      end else begin
        bus.mem_arready_i = 1'b0;
        bus.mem_rvalid_i  = 1'b0;
        bus.mem_rlast_i   = 1'b0;
        bus.fence_i_i     = 1'b0;
        if (bus.mem_arvalid_o) begin
          saw_ar = 1;
          if (bus.mem_araddr_o !== base || bus.mem_arlen_o !== 8'd3) ar_bad = 1;
          bus.mem_arready_i = (w >= ar_wait);
          w++;
        end
        if (bus.mem_rready_o && beat < 4) begin
          if (gaps_en && $urandom_range(0, 3) == 0) begin
            gaps++;
          end else begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = slave_word(base, beat);
            bus.mem_rlast_i  = (beat == 3);
            if (beat == fence_beat) bus.fence_i_i = 1'b1;
            beat++;
          end
        end
        @(negedge clk);
      end
    end
    bus.mem_arready_i = 1'b0;
    bus.mem_rvalid_i  = 1'b0;
    bus.mem_rlast_i   = 1'b0;
    bus.fence_i_i     = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.ifu_req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ifu_req_ready_o); end
    checks++; if (bus.ifu_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp got %b want 0", bus.ifu_rsp_valid_o); end
    checks++; if (bus.mem_arvalid_o !== 1'b0 || bus.mem_rready_o !== 1'b0) begin errors++; $display("FAIL reset_axi got ar=%b r=%b want 0 0", bus.mem_arvalid_o, bus.mem_rready_o); end
    checks++; if (bus.data_we_o !== 1'b0 || bus.tag_write_o !== 1'b0) begin errors++; $display("FAIL reset_we got we=%b tw=%b want 0 0", bus.data_we_o, bus.tag_write_o); end
    checks++; if (bus.ifu_rdata_o !== 32'h0 || bus.data_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_data got rd=%h wd=%h want 0 0", bus.ifu_rdata_o, bus.data_wdata_o); end
    checks++; if (bus.index_o !== 5'd0 || bus.tag_o !== 23'd0) begin errors++; $display("FAIL reset_addr got idx=%h tag=%h want 0 0", bus.index_o, bus.tag_o); end
  endtask

  task automatic test_cold_miss();
    logic [31:0] rd; int lat, gaps; bit saw, bad, ok;
    fetch(32'h0, 0, 0, -1, rd, lat, saw, bad, gaps, ok);
    checks++; if (saw !== 1'b1) begin errors++; $display("FAIL cold_miss_ar got %b want 1", saw); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL cold_araddr_arlen got bad=%b want 0", bad); end
    checks++; if (!ok || rd !== memfn(32'h0)) begin errors++; $display("FAIL cold_rdata got %h ok=%b want %h", rd, ok, memfn(32'h0)); end
  endtask

  task automatic test_refill();
    logic [31:0] rd; int lat, gaps, we0, tw0; bit saw, bad, ok;
    fixed_mode = 1'b1;
    we0 = we_cnt; tw0 = tw_cnt;
    fetch(32'h8000_0008, 0, 0, -1, rd, lat, saw, bad, gaps, ok);
    checks++; if (we_cnt - we0 !== 4) begin errors++; $display("FAIL refill_we_count got %0d want 4", we_cnt - we0); end
    checks++; if (beat_hist !== 8'h1B) begin errors++; $display("FAIL refill_beats got %h want 1b", beat_hist); end
    checks++; if (tw_cnt - tw0 !== 1) begin errors++; $display("FAIL refill_tag_writes got %0d want 1", tw_cnt - tw0); end
    checks++; if (tw_idx !== 5'd0 || tw_tag !== 23'h400000) begin errors++; $display("FAIL refill_tag got idx=%h tag=%h want 0 400000", tw_idx, tw_tag); end
    checks++; if (!ok || rd !== 32'h33) begin errors++; $display("FAIL refill_rdata got %h ok=%b want 33", rd, ok); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL refill_latency got %0d want 7", lat); end
  endtask

  task automatic test_hit();
    logic [31:0] rd; int lat, gaps; bit saw, bad, ok;
    fetch(32'h8000_000C, 0, 0, -1, rd, lat, saw, bad, gaps, ok);
    fixed_mode = 1'b0;
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL hit_no_ar got %b want 0", saw); end
    checks++; if (!ok || lat !== 1) begin errors++; $display("FAIL hit_latency got %0d ok=%b want 1", lat, ok); end
    checks++; if (rd !== 32'h44) begin errors++; $display("FAIL hit_rdata got %h want 44", rd); end
  endtask

  task automatic test_conflict();
    logic [31:0] rd; int lat, gaps; bit saw, bad, ok;
    fetch(32'h8000_1000, 0, 0, -1, rd, lat, saw, bad, gaps, ok);
    checks++; if (saw !== 1'b1 || rd !== memfn(32'h8000_1000)) begin errors++; $display("FAIL conflict_new_tag got ar=%b rd=%h want 1 %h", saw, rd, memfn(32'h8000_1000)); end
    fetch(32'h8000_0000, 0, 0, -1, rd, lat, saw, bad, gaps, ok);
    checks++; if (saw !== 1'b1 || rd !== memfn(32'h8000_0000)) begin errors++; $display("FAIL conflict_evicted got ar=%b rd=%h want 1 %h", saw, rd, memfn(32'h8000_0000)); end
  endtask

  task automatic test_fence_during_miss();
    logic [31:0] rd; int lat, gaps; bit saw, bad, ok;
    fetch(32'h8000_0100, 0, 0, 1, rd, lat, saw, bad, gaps, ok);
    checks++; if (!ok || rd !== memfn(32'h8000_0100)) begin errors++; $display("FAIL fence_rsp got %h ok=%b want %h", rd, ok, memfn(32'h8000_0100)); end
    @(negedge clk);
    checks++; if (bus.ifu_req_ready_o !== 1'b0) begin errors++; $display("FAIL fence_clear_cycle_ready got %b want 0", bus.ifu_req_ready_o); end
    fetch(32'h8000_0104, 0, 0, -1, rd, lat, saw, bad, gaps, ok);
    checks++; if (saw !== 1'b1) begin errors++; $display("FAIL fence_line_invalid got ar=%b want 1", saw); end
    clear_model();
  endtask

  task automatic test_ar_stall();
    logic [31:0] rd; int lat, gaps; bit saw, bad, ok;
    fetch(32'h8000_0140, 5, 0, -1, rd, lat, saw, bad, gaps, ok);
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL stall_ar_stable got bad=%b want 0", bad); end
    checks++; if (!ok || lat !== 12) begin errors++; $display("FAIL stall_latency got %0d ok=%b want 12", lat, ok); end
    checks++; if (rd !== memfn(32'h8000_0140)) begin errors++; $display("FAIL stall_rdata got %h want %h", rd, memfn(32'h8000_0140)); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] rd; int lat, gaps, n, tw0; bit saw, bad, ok;
    do_reset();
    tw0 = tw_cnt;
    bus.ifu_req_valid_i = 1'b1;
    bus.ifu_addr_i      = 32'h8000_0240;
    @(negedge clk);
    bus.ifu_req_valid_i = 1'b0;
    n = 0;
    while (!bus.mem_rready_o && n < 20) begin
      bus.mem_arready_i = bus.mem_arvalid_o;
      @(negedge clk);
      n++;
    end
    bus.mem_arready_i = 1'b0;
    checks++; if (bus.mem_rready_o !== 1'b1) begin errors++; $display("FAIL rstmid_reach_burst got rready=%b want 1", bus.mem_rready_o); end
    for (int b = 0; b < 2; b++) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'hDEAD_0000 + 32'(b);
      bus.mem_rlast_i  = 1'b0;
      @(negedge clk);
    end
    bus.mem_rvalid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.ifu_req_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", bus.ifu_req_ready_o); end
    checks++; if (bus.mem_rready_o !== 1'b0 || bus.mem_arvalid_o !== 1'b0) begin errors++; $display("FAIL rstmid_axi got r=%b ar=%b want 0 0", bus.mem_rready_o, bus.mem_arvalid_o); end
    checks++; if (tw_cnt !== tw0) begin errors++; $display("FAIL rstmid_no_tag_write got %0d want %0d", tw_cnt, tw0); end
    rst = 1'b0;
    clear_model();
    fetch(32'h8000_0240, 0, 0, -1, rd, lat, saw, bad, gaps, ok);
    checks++; if (saw !== 1'b1) begin errors++; $display("FAIL rstmid_line_invalid got ar=%b want 1", saw); end
    checks++; if (!ok || rd !== memfn(32'h8000_0240)) begin errors++; $display("FAIL rstmid_refetch got %h want %h", rd, memfn(32'h8000_0240)); end
  endtask

  task automatic test_random();
    logic [31:0] a, rd; logic [22:0] tg; logic [4:0] ix;
    int lat, gaps, ar_wait, exp_lat; bit saw, bad, ok, exp_hit;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 2))
        0:       tg = 23'h000123;
        1:       tg = 23'h400000;
        default: tg = 23'h7FFFFF;
      endcase
      ix = 5'($urandom_range(0, 3));
      a  = {tg, ix, 2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        bus.fence_i_i = 1'b1;
        #1;
        checks++; if (bus.ifu_req_ready_o !== 1'b0) begin errors++; $display("FAIL rand_fence_ready got %b want 0", bus.ifu_req_ready_o); end
        @(negedge clk);
        bus.fence_i_i = 1'b0;
        clear_model();
      end
      ar_wait = $urandom_range(0, 3);
      exp_hit = ref_valid[ix] && (ref_tag[ix] == tg);
      fetch(a, ar_wait, 1, -1, rd, lat, saw, bad, gaps, ok);
      exp_lat = exp_hit ? 1 : 7 + ar_wait + gaps;
      checks++; if (!ok) begin errors++; $display("FAIL rand_timeout addr=%h got no rsp want rsp", a); end
      checks++; if (saw !== !exp_hit) begin errors++; $display("FAIL rand_hitmiss addr=%h got ar=%b want %b", a, saw, !exp_hit); end
      checks++; if (rd !== memfn(a)) begin errors++; $display("FAIL rand_rdata addr=%h got %h want %h", a, rd, memfn(a)); end
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand_latency addr=%h got %0d want %0d", a, lat, exp_lat); end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rand_araddr addr=%h got bad=%b want 0", a, bad); end
      ref_valid[ix] = 1'b1;
      ref_tag[ix]   = tg;
    end
  endtask

  initial begin
    bus.ifu_req_valid_i = 1'b0;
    bus.ifu_addr_i      = '0;
    bus.fence_i_i       = 1'b0;
    bus.mem_arready_i   = 1'b0;
    bus.mem_rvalid_i    = 1'b0;
    bus.mem_rdata_i     = '0;
    bus.mem_rlast_i     = 1'b0;
    test_reset();
    test_cold_miss();
    test_refill();
    test_hit();
    test_conflict();
    test_fence_during_miss();
    test_ar_stall();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
